// File: rtl/uarith_seq_stage_if.sv
// +--------------------------------------------------------------------+
// | uarith_seq_stage_if: request, result and arithmetic-unit signals     |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

interface uarith_seq_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_answer;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [1:0]       out_op;
  logic             out_zero;
  logic             out_div_zero;
  logic             busy;

  // Master is the surrounding system: requester, result sink and the arithmetic unit.
  modport master (
    output in_valid, in_a, in_b, in_op, out_ready, alu_answer,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
           out_op, out_zero, out_div_zero, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready, alu_answer,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_result,
           out_op, out_zero, out_div_zero, busy
  );
endinterface

`default_nettype wire

// File: rtl/uarith_seq_stage.sv
// +--------------------------------------------------------------------+
// | uarith_seq_stage: issue/settle/retire stage around a combinational   |
// | unsigned arithmetic unit. Revision: 1.0                              |
// +--------------------------------------------------------------------+
`default_nettype none

module uarith_seq_stage #(
  parameter int WIDTH             = 32,
  parameter int SETTLE_CYCLES     = 4,
  parameter int DIV_SETTLE_CYCLES = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uarith_seq_stage_if.slave bus
);

  localparam logic [3:0] c_settle     = 4'(SETTLE_CYCLES);
  localparam logic [3:0] c_div_settle = 4'(DIV_SETTLE_CYCLES);
  localparam logic [1:0] c_op_div     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       rop_q, rop_d;
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
  logic             ovalid_q, ovalid_d;

  logic             in_ready_w;
  logic             accept_w;
  logic             div_zero_w;

  assign in_ready_w = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
  assign accept_w   = bus.in_valid && in_ready_w;
  assign div_zero_w = (bus.in_op == c_op_div) && (bus.in_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'd0;
      res_q    <= '0;
      rop_q    <= 2'd0;
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      res_q    <= res_d;
      rop_q    <= rop_d;
      zero_q   <= zero_d;
      dz_q     <= dz_d;
      ovalid_q <= ovalid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    res_d    = res_q;
    rop_d    = rop_q;
    zero_d   = zero_q;
    dz_d     = dz_q;
    ovalid_d = ovalid_q;

    case (state_q)
      S_IDLE: begin
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          res_d    = bus.alu_answer;
          zero_d   = (bus.alu_answer == '0);
          dz_d     = 1'b0;
          rop_d    = alu_op_q;
          ovalid_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ovalid_d = 1'b0;
      end
    endcase

    // An accept in HOLD overrides the plain retire above.
    if (accept_w) begin
      alu_a_d  = bus.in_a;
      alu_b_d  = bus.in_b;
      alu_op_d = bus.in_op;
      if (div_zero_w) begin
        res_d    = '1;
        rop_d    = c_op_div;
        zero_d   = 1'b0;
        dz_d     = 1'b1;
        ovalid_d = 1'b1;
        state_d  = S_HOLD;
      end else begin
        cnt_d    = (bus.in_op == c_op_div) ? c_div_settle : c_settle;
        ovalid_d = 1'b0;
        state_d  = S_WAIT;
      end
    end
  end

  assign bus.in_ready     = in_ready_w;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.out_valid    = ovalid_q;
  assign bus.out_result   = res_q;
  assign bus.out_op       = rop_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_div_zero = dz_q;
  assign bus.busy         = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uarith_seq_stage.sv
// +--------------------------------------------------------------------+
// | tb_uarith_seq_stage: directed bench with result scoreboard           |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_uarith_seq_stage;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic [1:0]   op;
    logic         zero;
    logic         dz;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   pops      = 0;
  int   pushes    = 0;
  int   discarded = 0;
  exp_t sb[$];

  uarith_seq_stage_if #(.WIDTH(W)) bus ();

  uarith_seq_stage #(
    .WIDTH(W),
    .SETTLE_CYCLES(4),
    .DIV_SETTLE_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference arithmetic unit; divide by zero returns 0, which the stage must ignore.
  function automatic logic [W-1:0] unit_model(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return p[W-1:0];
      default: return (b == '0) ? '0 : a / b;
    endcase
  endfunction

  assign bus.alu_answer = unit_model(bus.alu_a, bus.alu_b, bus.alu_op);

  function automatic exp_t expect_of(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    if (op == 2'd3 && b == '0) begin
      e.res = '1; e.op = 2'd3; e.zero = 1'b0; e.dz = 1'b1;
    end else begin
      e.res = unit_model(a, b, op); e.op = op; e.zero = (e.res == '0); e.dz = 1'b0;
    end
    return e;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(string tag);
    int n = 0;
    while (!bus.in_ready && n < 50) begin tick(); n++; end
    check({tag, "_ready_timeout"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic wait_valid(string tag, int exp_lat);
    int lat = 0;
    while (!bus.out_valid && lat < 40) begin tick(); lat++; end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic push(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    sb.push_back(expect_of(op, a, b));
    pushes++;
  endtask

  task automatic drive(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
    bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
  endtask

  task automatic issue(string tag, logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b, int exp_lat);
    drive(op, a, b);
    wait_ready(tag);
    push(op, a, b);
    tick();
    bus.in_valid = 1'b0;
    wait_valid(tag, exp_lat);
  endtask

  // Scoreboard: a result is consumed on any cycle that ends in a valid/ready handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL sb_unexpected: observed result=%0h expected none", bus.out_result);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        pops++;
        check("sb_result", 64'(bus.out_result), 64'(e.res));
        check("sb_op", 64'(bus.out_op), 64'(e.op));
        check("sb_zero", 64'(bus.out_zero), 64'(e.zero));
        check("sb_div_zero", 64'(bus.out_div_zero), 64'(e.dz));
      end
    end
  end

  initial begin
    logic [W-1:0] ba [4];
    logic [W-1:0] bb [4];
    int bad;
    ba = '{32'd10, 32'hFFFF_FFFF, 32'd100, 32'd7};
    bb = '{32'd20, 32'd1,         32'd200, 32'd8};

    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 2'd0; bus.out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_out_result", 64'(bus.out_result), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    bus.out_ready = 1'b1;
    issue("add", 2'd0, 32'd5, 32'd7, 4);
    check("add_result", 64'(bus.out_result), 64'd12);
    check("add_zero", 64'(bus.out_zero), 64'd0);
    check("add_op", 64'(bus.out_op), 64'd0);
    tick();
    check("add_retired_valid", 64'(bus.out_valid), 64'd0);
    check("add_retired_ready", 64'(bus.in_ready), 64'd1);

    issue("sub_eq", 2'd1, 32'd9, 32'd9, 4);
    check("sub_eq_zero", 64'(bus.out_zero), 64'd1);
    issue("mul", 2'd2, 32'h1_0000, 32'h1_0000, 4);
    check("mul_zero", 64'(bus.out_zero), 64'd1);
    issue("sub_wrap", 2'd1, 32'd3, 32'd5, 4);
    check("sub_wrap_result", 64'(bus.out_result), 64'hFFFF_FFFE);

    issue("div", 2'd3, 32'd100, 32'd7, 8);
    check("div_result", 64'(bus.out_result), 64'd14);
    issue("div0", 2'd3, 32'd1, 32'd0, 0);
    check("div0_result", 64'(bus.out_result), 64'hFFFF_FFFF);
    check("div0_flag", 64'(bus.out_div_zero), 64'd1);
    tick();

    // Backpressure with a pending request presented throughout.
    bus.out_ready = 1'b0;
    issue("bp_add", 2'd0, 32'd1, 32'd1, 4);
    drive(2'd0, 32'd20, 32'd22);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_result !== 32'd2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
          bus.alu_a !== 32'd1 || bus.alu_b !== 32'd1) bad++;
    end
    check("bp_stall_stable", 64'(bad), 64'd0);
    check("bp_hold_result", 64'(bus.out_result), 64'd2);
    push(2'd0, 32'd20, 32'd22);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp_new_alu_a", 64'(bus.alu_a), 64'd20);
    check("bp_new_alu_b", 64'(bus.alu_b), 64'd22);
    check("bp_valid_cleared", 64'(bus.out_valid), 64'd0);
    check("bp_busy", 64'(bus.busy), 64'd1);
    wait_valid("bp_pending", 4);
    check("bp_pending_result", 64'(bus.out_result), 64'd42);
    tick();

    // Back-to-back with in_valid and out_ready held high.
    drive(2'd0, ba[0], bb[0]);
    wait_ready("b2b");
    push(2'd0, ba[0], bb[0]);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(2'd0, ba[k+1], bb[k+1]);
      else bus.in_valid = 1'b0;
      wait_valid("b2b", 4);
      check("b2b_alu_a_held", 64'(bus.alu_a), 64'(ba[k]));
      if (k < 3) begin
        check("b2b_ready", 64'(bus.in_ready), 64'd1);
        push(2'd0, ba[k+1], bb[k+1]);
        tick();
      end
    end
    tick();
    check("b2b_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset during the settle interval of a divide.
    issue("pre_rst", 2'd0, 32'd3, 32'd4, 4);
    tick();
    drive(2'd3, 32'd50, 32'd5);
    push(2'd3, 32'd50, 32'd5);
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    discarded = sb.size();
    sb.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("mid_rst_alu_b", 64'(bus.alu_b), 64'd0);
    check("mid_rst_alu_op", 64'(bus.alu_op), 64'd0);
    check("mid_rst_result", 64'(bus.out_result), 64'd0);
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.in_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      tick();
    end
    check("post_rst_no_stale", 64'(bad), 64'd0);
    check("sb_all_popped", 64'(pops), 64'(pushes - discarded));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
